// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Results are computed at the start edge and committed to HI/LO after a fixed busy window.
module md_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              busy_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic [WIDTH-1:0]  res_hi_q;
    logic [WIDTH-1:0]  res_lo_q;
    logic              res_wr_q;

    logic [WIDTH-1:0]   res_hi_d;
    logic [WIDTH-1:0]   res_lo_d;
    logic               res_wr_d;
    logic [CntW-1:0]    cnt_d;

    logic               a_neg;
    logic               b_neg;
    logic               div_zero;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [WIDTH-1:0]   divisor_u;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   quo_u;
    logic [WIDTH-1:0]   rem_u;
    logic [WIDTH-1:0]   quo_m;
    logic [WIDTH-1:0]   rem_m;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    always_comb begin
        a_neg    = src_a[WIDTH-1];
        b_neg    = src_b[WIDTH-1];
        div_zero = (src_b == '0);

        // Sign-extended operands make the low 2*WIDTH bits of an unsigned product the signed one.
        prod_s = {{WIDTH{a_neg}}, src_a} * {{WIDTH{b_neg}}, src_b};
        prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

        divisor_u = div_zero ? WIDTH'(1) : src_b;
        quo_u     = src_a / divisor_u;
        rem_u     = src_a % divisor_u;

        // Divide magnitudes, then restore signs: truncation toward zero, remainder follows dividend.
        mag_a = a_neg ? (~src_a + WIDTH'(1)) : src_a;
        mag_b = div_zero ? WIDTH'(1) : (b_neg ? (~src_b + WIDTH'(1)) : src_b);
        quo_m = mag_a / mag_b;
        rem_m = mag_a % mag_b;
        quo_s = (a_neg ^ b_neg) ? (~quo_m + WIDTH'(1)) : quo_m;
        rem_s = a_neg ? (~rem_m + WIDTH'(1)) : rem_m;

        res_hi_d = '0;
        res_lo_d = '0;
        res_wr_d = 1'b0;
        cnt_d    = '0;
        case (op)
            OpMult: begin
                res_hi_d = prod_s[2*WIDTH-1:WIDTH];
                res_lo_d = prod_s[WIDTH-1:0];
                res_wr_d = 1'b1;
                cnt_d    = CntW'(MULT_CYCLES - 1);
            end
            OpMultu: begin
                res_hi_d = prod_u[2*WIDTH-1:WIDTH];
                res_lo_d = prod_u[WIDTH-1:0];
                res_wr_d = 1'b1;
                cnt_d    = CntW'(MULT_CYCLES - 1);
            end
            OpDiv: begin
                res_hi_d = rem_s;
                res_lo_d = quo_s;
                res_wr_d = ~div_zero;
                cnt_d    = CntW'(DIV_CYCLES - 1);
            end
            OpDivu: begin
                res_hi_d = rem_u;
                res_lo_d = quo_u;
                res_wr_d = ~div_zero;
                cnt_d    = CntW'(DIV_CYCLES - 1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            res_wr_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        case (op)
                            OpMult, OpMultu, OpDiv, OpDivu: begin
                                res_hi_q <= res_hi_d;
                                res_lo_q <= res_lo_d;
                                res_wr_q <= res_wr_d;
                                cnt_q    <= cnt_d;
                                busy_q   <= 1'b1;
                                state_q  <= StBusy;
                            end
                            OpMthi: hi_q <= src_a;
                            OpMtlo: lo_q <= src_a;
                            default: ;
                        endcase
                    end
                end
                StBusy: begin
                    // New starts are dropped here; the hazard unit never issues them.
                    if (cnt_q == '0) begin
                        if (res_wr_q) begin
                            hi_q <= res_hi_q;
                            lo_q <= res_lo_q;
                        end
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed corner cases plus randomized ops against an arithmetic reference model.
module tb_md_unit;

    localparam int unsigned WIDTH       = 32;
    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;

    logic             clk;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    md_unit #(
        .WIDTH      (WIDTH),
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .src_a(src_a),
        .src_b(src_b),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] h, inout logic [31:0] l, output int n);
        longint          sp;
        longint unsigned up;
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        n = 0;
        case (mop)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                h  = sp[63:32];
                l  = sp[31:0];
                n  = MULT_CYCLES;
            end
            3'd1: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                h  = up[63:32];
                l  = up[31:0];
                n  = MULT_CYCLES;
            end
            3'd2: begin
                if (b != 0) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    l  = q[31:0];
                    h  = r[31:0];
                end
                n = DIV_CYCLES;
            end
            3'd3: begin
                if (b != 0) begin
                    l = a / b;
                    h = a % b;
                end
                n = DIV_CYCLES;
            end
            3'd4: h = a;
            3'd5: l = a;
            default: ;
        endcase
    endtask

    // Issue one op from idle and check the full busy window; stray starts optionally injected.
    task automatic issue(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                         input bit stray);
        logic [31:0] nh;
        logic [31:0] nl;
        int          n;
        nh = exp_hi;
        nl = exp_lo;
        model(mop, a, b, nh, nl, n);
        start = 1'b1;
        op    = mop;
        src_a = a;
        src_b = b;
        tick();
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        for (int i = 0; i < n; i++) begin
            check($sformatf("busy op%0d c%0d", mop, i), 64'(busy), 64'(1));
            check($sformatf("hi hold op%0d c%0d", mop, i), 64'(hi), 64'(exp_hi));
            check($sformatf("lo hold op%0d c%0d", mop, i), 64'(lo), 64'(exp_lo));
            if (stray && ($urandom_range(0, 3) == 0)) begin
                start = 1'b1;
                op    = 3'($urandom_range(0, 7));
            end
            tick();
            start = 1'b0;
        end
        exp_hi = nh;
        exp_lo = nl;
        check($sformatf("busy done op%0d", mop), 64'(busy), 64'(0));
        check($sformatf("hi op%0d a=%h b=%h", mop, a, b), 64'(hi), 64'(exp_hi));
        check($sformatf("lo op%0d a=%h b=%h", mop, a, b), 64'(lo), 64'(exp_lo));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        start = 1'b1;
        op    = 3'd0;
        src_a = 32'h0000_0005;
        src_b = 32'h0000_0007;
        tick();
        tick();
        check("reset busy", 64'(busy), 64'(0));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("post-reset busy", 64'(busy), 64'(0));
        check("post-reset hi", 64'(hi), 64'(0));

        issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        check("mult -2*3 hi", 64'(hi), 64'(32'hFFFF_FFFF));
        check("mult -2*3 lo", 64'(lo), 64'(32'hFFFF_FFFA));
        issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        check("multu hi", 64'(hi), 64'(32'h0000_0001));
        check("multu lo", 64'(lo), 64'(32'hFFFF_FFFE));
        issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        check("div -7/2 lo", 64'(lo), 64'(32'hFFFF_FFFD));
        check("div -7/2 hi", 64'(hi), 64'(32'hFFFF_FFFF));
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div min/-1 lo", 64'(lo), 64'(32'h8000_0000));
        check("div min/-1 hi", 64'(hi), 64'(32'h0000_0000));

        // MTHI/MTLO write at the start edge without raising busy.
        start = 1'b1; op = 3'd4; src_a = 32'h0000_1234;
        tick();
        check("mthi busy", 64'(busy), 64'(0));
        check("mthi hi", 64'(hi), 64'(32'h0000_1234));
        op = 3'd5; src_a = 32'h0000_5678;
        tick();
        start = 1'b0;
        check("mtlo busy", 64'(busy), 64'(0));
        check("mtlo lo", 64'(lo), 64'(32'h0000_5678));
        check("mtlo hi kept", 64'(hi), 64'(32'h0000_1234));
        exp_hi = 32'h0000_1234;
        exp_lo = 32'h0000_5678;

        start = 1'b1; op = 3'd6; src_a = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        check("nop busy", 64'(busy), 64'(0));
        check("nop hi", 64'(hi), 64'(exp_hi));

        issue(3'd3, 32'hCAFE_0001, 32'h0000_0000, 1'b0);
        check("divu /0 hi", 64'(hi), 64'(32'h0000_1234));
        check("divu /0 lo", 64'(lo), 64'(32'h0000_5678));

        // MTHI during a divide must be dropped.
        start = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd7;
        tick();
        op = 3'd4; src_a = 32'hBAD0_BAD0;
        tick();
        start = 1'b0;
        for (int i = 0; i < int'(DIV_CYCLES) - 1; i++) tick();
        check("mthi-in-busy busy", 64'(busy), 64'(0));
        check("mthi-in-busy hi", 64'(hi), 64'(32'd2));
        check("mthi-in-busy lo", 64'(lo), 64'(32'd14));
        exp_hi = 32'd2;
        exp_lo = 32'd14;

        // Reset in the fourth busy cycle discards the result.
        start = 1'b1; op = 3'd2; src_a = 32'd1000; src_b = 32'd3;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("mid busy", 64'(busy), 64'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid reset busy", 64'(busy), 64'(0));
        check("mid reset hi", 64'(hi), 64'(0));
        check("mid reset lo", 64'(lo), 64'(0));
        exp_hi = '0;
        exp_lo = '0;
        for (int i = 0; i < int'(DIV_CYCLES); i++) tick();
        check("no late commit hi", 64'(hi), 64'(0));
        check("no late commit lo", 64'(lo), 64'(0));

        // Back-to-back: issue() starts the next op in the cycle busy falls.
        issue(3'd2, 32'd45, 32'd6, 1'b0);
        issue(3'd0, 32'h0001_0003, 32'hFFFF_0005, 1'b0);

        for (int k = 0; k < 150; k++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
